// File: rtl/eeprom_arb.sv
// eeprom_arb: two-client round-robin arbiter and sequencer in front of a
// single-byte I2C EEPROM master engine. One engine transaction is in flight
// at a time; address/data are held until the engine acks, read data is
// captured per client, and every write is followed by a tWR quiet period.
//
// Optional feature: define EEPROM_ARB_TIMEOUT_EN to add a WAIT_ACK timeout
// (TIMEOUT_CYCLES) that completes the transaction with cX_err = 1.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cX_req/we/addr/wdata  client X request (level, held until cX_gnt)
//   cX_gnt                one-cycle pulse: request accepted
//   cX_done/err           one-cycle completion pulse, err = timeout
//   cX_rdata              last read data returned to client X
//   eng_wr/eng_rd         one-cycle engine strobes
//   eng_addr/eng_data_o   engine address / write data, held through ack
//   eng_data_oe           tri-state enable for the engine data bus
//   eng_data_i, eng_ack   engine read data and completion pulse
//   busy                  arbiter not idle
module eeprom_arb #(
  parameter int unsigned TWR_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c0_req,
  input  logic        c0_we,
  input  logic [10:0] c0_addr,
  input  logic [7:0]  c0_wdata,
  output logic        c0_gnt,
  output logic        c0_done,
  output logic [7:0]  c0_rdata,
  output logic        c0_err,
  input  logic        c1_req,
  input  logic        c1_we,
  input  logic [10:0] c1_addr,
  input  logic [7:0]  c1_wdata,
  output logic        c1_gnt,
  output logic        c1_done,
  output logic [7:0]  c1_rdata,
  output logic        c1_err,
  output logic        eng_wr,
  output logic        eng_rd,
  output logic [10:0] eng_addr,
  output logic [7:0]  eng_data_o,
  output logic        eng_data_oe,
  input  logic [7:0]  eng_data_i,
  input  logic        eng_ack,
  output logic        busy
);

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TWR_LOAD = CW'(TWR_CYCLES);
  localparam logic          TWR_EN   = (TWR_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WRCYC} state_e;

  state_e          state_q, state_d;
  logic            own_q, own_d;
  logic            we_q, we_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            c0_gnt_q, c0_gnt_d, c1_gnt_q, c1_gnt_d;
  logic            c0_done_q, c0_done_d, c1_done_q, c1_done_d;
  logic            c0_err_q, c0_err_d, c1_err_q, c1_err_d;
  logic [DW-1:0]   c0_rdata_q, c0_rdata_d, c1_rdata_q, c1_rdata_d;
  logic            eng_wr_q, eng_wr_d, eng_rd_q, eng_rd_d;
  logic [AW-1:0]   eng_addr_q, eng_addr_d;
  logic [DW-1:0]   eng_data_q, eng_data_d;
  logic            eng_oe_q, eng_oe_d;
  logic            busy_q, busy_d;
  logic            pick, gnt_any, done_any, err_any;

`ifdef EEPROM_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0]   to_q, to_d;
`else
  logic            unused_timeout;
  assign unused_timeout = ^CW'(TIMEOUT_CYCLES);
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    own_d      = own_q;
    we_d       = we_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    eng_addr_d = eng_addr_q;
    eng_data_d = eng_data_q;
    eng_oe_d   = eng_oe_q;
    c0_rdata_d = c0_rdata_q;
    c1_rdata_d = c1_rdata_q;
    eng_wr_d   = 1'b0;
    eng_rd_d   = 1'b0;
    gnt_any    = 1'b0;
    done_any   = 1'b0;
    err_any    = 1'b0;
    pick       = 1'b0;
`ifdef EEPROM_ARB_TIMEOUT_EN
    to_d       = to_q;
`endif

    case (state_q)
      IDLE: begin
        if (c0_req || c1_req) begin
          // On a tie the client not served last wins
          pick       = (c0_req && c1_req) ? ~last_q : c1_req;
          own_d      = pick;
          we_d       = pick ? c1_we    : c0_we;
          eng_addr_d = pick ? c1_addr  : c0_addr;
          eng_data_d = pick ? c1_wdata : c0_wdata;
          gnt_any    = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        eng_wr_d = we_q;
        eng_rd_d = ~we_q;
        eng_oe_d = we_q;
        state_d  = WAIT_ACK;
`ifdef EEPROM_ARB_TIMEOUT_EN
        to_d     = '0;
`endif
      end
      WAIT_ACK: begin
        if (eng_ack) begin
          // Read data is sampled in the ack cycle itself
          if (!we_q) begin
            if (own_q) c1_rdata_d = eng_data_i;
            else       c0_rdata_d = eng_data_i;
          end
          done_any = 1'b1;
          eng_oe_d = 1'b0;
          last_d   = own_q;
          if (we_q && TWR_EN) begin
            cnt_d   = TWR_LOAD;
            state_d = WRCYC;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef EEPROM_ARB_TIMEOUT_EN
        else if (to_q == TO_LIMIT) begin
          // Give up on the engine; still honour tWR before the next request
          done_any = 1'b1;
          err_any  = 1'b1;
          eng_oe_d = 1'b0;
          last_d   = own_q;
          if (TWR_EN) begin
            cnt_d   = TWR_LOAD;
            state_d = WRCYC;
          end else begin
            state_d = IDLE;
          end
        end else begin
          to_d = to_q + CW'(1);
        end
`endif
      end
      WRCYC: begin
        // Counter loaded with TWR_CYCLES gives exactly that many WRCYC cycles
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    c0_gnt_d  = gnt_any & ~pick;
    c1_gnt_d  = gnt_any & pick;
    c0_done_d = done_any & ~own_q;
    c1_done_d = done_any & own_q;
    c0_err_d  = err_any & ~own_q;
    c1_err_d  = err_any & own_q;
    busy_d    = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      own_q      <= 1'b0;
      we_q       <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      c0_gnt_q   <= 1'b0;
      c1_gnt_q   <= 1'b0;
      c0_done_q  <= 1'b0;
      c1_done_q  <= 1'b0;
      c0_err_q   <= 1'b0;
      c1_err_q   <= 1'b0;
      c0_rdata_q <= '0;
      c1_rdata_q <= '0;
      eng_wr_q   <= 1'b0;
      eng_rd_q   <= 1'b0;
      eng_addr_q <= '0;
      eng_data_q <= '0;
      eng_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef EEPROM_ARB_TIMEOUT_EN
      to_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      we_q       <= we_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      c0_gnt_q   <= c0_gnt_d;
      c1_gnt_q   <= c1_gnt_d;
      c0_done_q  <= c0_done_d;
      c1_done_q  <= c1_done_d;
      c0_err_q   <= c0_err_d;
      c1_err_q   <= c1_err_d;
      c0_rdata_q <= c0_rdata_d;
      c1_rdata_q <= c1_rdata_d;
      eng_wr_q   <= eng_wr_d;
      eng_rd_q   <= eng_rd_d;
      eng_addr_q <= eng_addr_d;
      eng_data_q <= eng_data_d;
      eng_oe_q   <= eng_oe_d;
      busy_q     <= busy_d;
`ifdef EEPROM_ARB_TIMEOUT_EN
      to_q       <= to_d;
`endif
    end
  end

  assign c0_gnt      = c0_gnt_q;
  assign c1_gnt      = c1_gnt_q;
  assign c0_done     = c0_done_q;
  assign c1_done     = c1_done_q;
  assign c0_err      = c0_err_q;
  assign c1_err      = c1_err_q;
  assign c0_rdata    = c0_rdata_q;
  assign c1_rdata    = c1_rdata_q;
  assign eng_wr      = eng_wr_q;
  assign eng_rd      = eng_rd_q;
  assign eng_addr    = eng_addr_q;
  assign eng_data_o  = eng_data_q;
  assign eng_data_oe = eng_oe_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_eeprom_arb.sv
// tb_eeprom_arb: directed and randomized stimulus for eeprom_arb, checked every
// cycle against a transaction-timeline model (grant/ack/done cycle numbers),
// plus hand-computed literal checks for the key latencies.
module tb_eeprom_arb;
  localparam int TWR   = 8;
  localparam int TO    = 100;
  localparam int NEVER = 1 << 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c0_req = 1'b0, c0_we = 1'b0;
  logic [10:0] c0_addr = '0;
  logic [7:0]  c0_wdata = '0;
  logic        c1_req = 1'b0, c1_we = 1'b0;
  logic [10:0] c1_addr = '0;
  logic [7:0]  c1_wdata = '0;
  logic [7:0]  eng_data_i = '0;
  logic        eng_ack = 1'b0;
  logic        c0_gnt, c0_done, c0_err, c1_gnt, c1_done, c1_err;
  logic [7:0]  c0_rdata, c1_rdata;
  logic        eng_wr, eng_rd, eng_data_oe, busy;
  logic [10:0] eng_addr;
  logic [7:0]  eng_data_o;

  always #5 clk = ~clk;

  eeprom_arb #(.TWR_CYCLES(TWR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_gnt(c0_gnt), .c0_done(c0_done), .c0_rdata(c0_rdata), .c0_err(c0_err),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_gnt(c1_gnt), .c1_done(c1_done), .c1_rdata(c1_rdata), .c1_err(c1_err),
    .eng_wr(eng_wr), .eng_rd(eng_rd), .eng_addr(eng_addr), .eng_data_o(eng_data_o),
    .eng_data_oe(eng_data_oe), .eng_data_i(eng_data_i), .eng_ack(eng_ack), .busy(busy)
  );

  int total = 0, bad = 0, cyc = 0;

  // Model: timeline of the current transaction
  int t_gnt = -1, t_ack = -1, t_done = -1, idle_at = 0, m_own = 0, m_last = 1;
  bit m_we = 0, m_err = 0;
  logic [10:0] m_addr = '0;
  logic [7:0]  m_wdata = '0;
  logic [7:0]  m_rd [2];

  // Stimulus knobs and observed events
  bit rst_req = 1, rand_rst = 0, spur = 0, eng_hang = 0, eng_pend = 0;
  bit keep0 = 0, keep1 = 0;
  int p0 = 0, p1 = 0, eng_delay = 0, eng_cnt = 0, eng_rfix = -1;
  int last_gnt_cyc [2], last_done_cyc [2];
  int last_strobe_cyc = 0, last_ack_cyc = 0, fall_cyc = 0;
  int wr_cnt = 0, oe_cnt = 0, done_cnt0 = 0, done_cnt1 = 0;
  bit last_err0 = 0, prev_busy = 0;
  logic [10:0] ack_addr;
  logic [7:0]  ack_data;
  logic        ack_oe;
  int gnt_log [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_update();
    int w;
    if (reset) begin
      t_gnt = -1; t_ack = -1; t_done = -1; idle_at = 0; m_last = 1; m_err = 0;
      m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0; m_own = 0; m_we = 0;
      return;
    end
    if (cyc >= idle_at) begin
      if (c0_req || c1_req) begin
        w = (c0_req && c1_req) ? ((m_last == 0) ? 1 : 0) : (c0_req ? 0 : 1);
        m_own = w;
        m_we = (w == 1) ? c1_we : c0_we;
        m_addr = (w == 1) ? c1_addr : c0_addr;
        m_wdata = (w == 1) ? c1_wdata : c0_wdata;
        t_gnt = cyc + 1; t_ack = -1; t_done = -1; m_err = 0; idle_at = NEVER;
      end
    end else if (t_gnt >= 0 && t_ack < 0 && cyc >= t_gnt + 1) begin
      if (eng_ack) begin
        t_ack = cyc; t_done = cyc + 1; m_err = 0; m_last = m_own;
        if (!m_we) m_rd[m_own] = eng_data_i;
        idle_at = cyc + 1 + (m_we ? TWR : 0);
      end
`ifdef EEPROM_ARB_TIMEOUT_EN
      else if (cyc - (t_gnt + 1) == TO - 1) begin
        t_ack = cyc; t_done = cyc + 1; m_err = 1; m_last = m_own;
        idle_at = cyc + 1 + TWR;
      end
`endif
    end
  endtask

  task automatic compare();
    bit act_tx, own1, wait_oe;
    act_tx  = (t_gnt >= 0);
    own1    = (m_own == 1);
    wait_oe = act_tx && m_we && cyc >= t_gnt + 1 && (t_ack < 0 || cyc <= t_ack);
    chk("c0_gnt", c0_gnt, act_tx && t_gnt == cyc && !own1);
    chk("c1_gnt", c1_gnt, act_tx && t_gnt == cyc && own1);
    chk("eng_wr", eng_wr, act_tx && cyc == t_gnt + 1 && m_we);
    chk("eng_rd", eng_rd, act_tx && cyc == t_gnt + 1 && !m_we);
    chk("eng_data_oe", eng_data_oe, wait_oe);
    chk("eng_addr", eng_addr, m_addr);
    chk("eng_data_o", eng_data_o, m_wdata);
    chk("c0_done", c0_done, t_done == cyc && !own1);
    chk("c1_done", c1_done, t_done == cyc && own1);
    chk("c0_err", c0_err, t_done == cyc && !own1 && m_err);
    chk("c1_err", c1_err, t_done == cyc && own1 && m_err);
    chk("c0_rdata", c0_rdata, m_rd[0]);
    chk("c1_rdata", c1_rdata, m_rd[1]);
    chk("busy", busy, act_tx && cyc >= t_gnt && cyc < idle_at);
    if (c0_gnt) begin last_gnt_cyc[0] = cyc; gnt_log.push_back(0); end
    if (c1_gnt) begin last_gnt_cyc[1] = cyc; gnt_log.push_back(1); end
    if (eng_wr || eng_rd) last_strobe_cyc = cyc;
    if (eng_wr) wr_cnt++;
    if (eng_data_oe) oe_cnt++;
    if (c0_done) begin last_done_cyc[0] = cyc; done_cnt0++; last_err0 = c0_err; end
    if (c1_done) begin last_done_cyc[1] = cyc; done_cnt1++; end
    if (prev_busy && !busy) fall_cyc = cyc;
    prev_busy = busy;
  endtask

  task automatic rand0();
    c0_we = 1'($urandom_range(1)); c0_addr = 11'($urandom); c0_wdata = 8'($urandom);
  endtask

  task automatic rand1();
    c1_we = 1'($urandom_range(1)); c1_addr = 11'($urandom); c1_wdata = 8'($urandom);
  endtask

  task automatic drive();
    if (rand_rst) rst_req = ($urandom_range(999) == 0);
    reset = rst_req;
    eng_ack = 1'b0;
    eng_data_i = 8'($urandom);
    if (rst_req) begin
      eng_pend = 0;
    end else begin
      if (eng_wr || eng_rd) begin
        eng_pend = 1;
        eng_cnt = (eng_delay < 0) ? int'($urandom_range(6)) : eng_delay;
      end
      if (eng_pend && !eng_hang) begin
        if (eng_cnt == 0) begin
          eng_ack = 1'b1; eng_pend = 0; last_ack_cyc = cyc;
          if (eng_rfix >= 0) eng_data_i = 8'(eng_rfix);
          ack_addr = eng_addr; ack_data = eng_data_o; ack_oe = eng_data_oe;
        end else begin
          eng_cnt--;
        end
      end else if (!eng_pend && spur && $urandom_range(49) == 0) begin
        eng_ack = 1'b1;
      end
    end
    if (c0_req && c0_gnt) begin
      if (keep0) rand0(); else c0_req = 1'b0;
    end else if (!c0_req && int'($urandom_range(99)) < p0) begin
      c0_req = 1'b1; rand0();
    end
    if (c1_req && c1_gnt) begin
      if (keep1) rand1(); else c1_req = 1'b0;
    end else if (!c1_req && int'($urandom_range(99)) < p1) begin
      c1_req = 1'b1; rand1();
    end
  endtask

  task automatic tick();
    model_update();
    @(negedge clk);
    cyc++;
    compare();
    drive();
  endtask

  task automatic wait_idle(input int bound, input string nm);
    for (int i = 0; i < bound; i++) begin
      if (!c0_req && !c1_req && (!eng_pend || eng_hang) && cyc >= idle_at && !busy) return;
      tick();
    end
    total++; bad++;
    $display("FAIL %s cycle=%0d got=not idle expected=idle within %0d cycles", nm, cyc, bound);
  endtask

  task automatic do_reset();
    rst_req = 1; reset = 1'b1; eng_pend = 0;
    tick();
    rst_req = 0; reset = 1'b0;
  endtask

  initial begin
    m_rd[0] = '0; m_rd[1] = '0;
    last_gnt_cyc[0] = 0; last_gnt_cyc[1] = 0; last_done_cyc[0] = 0; last_done_cyc[1] = 0;

    // Reset values
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_c0_rdata", c0_rdata, 8'h00);
    chk("rst_eng_addr", eng_addr, 11'h000);
    rst_req = 0; reset = 1'b0;
    tick();

    // c0 write 0x123 <- 0xA5, engine acks 40 cycles after the strobe
    eng_delay = 40; wr_cnt = 0; done_cnt0 = 0;
    c0_req = 1'b1; c0_we = 1'b1; c0_addr = 11'h123; c0_wdata = 8'hA5;
    wait_idle(300, "t_write_idle");
    chk("t_write_strobe_lat", last_strobe_cyc - last_gnt_cyc[0], 1);
    chk("t_write_ack_delay", last_ack_cyc - last_strobe_cyc, 40);
    chk("t_write_done_lat", last_done_cyc[0] - last_ack_cyc, 1);
    chk("t_write_wrcyc", fall_cyc - last_done_cyc[0], 8);
    chk("t_write_wr_width", wr_cnt, 1);
    chk("t_write_ack_addr", ack_addr, 11'h123);
    chk("t_write_ack_data", ack_data, 8'hA5);
    chk("t_write_ack_oe", ack_oe, 1);
    chk("t_write_done_cnt", done_cnt0, 1);

    // c1 read 0x7FF, engine returns 0x3C
    eng_delay = 3; eng_rfix = 8'h3C; oe_cnt = 0;
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 11'h7FF;
    wait_idle(100, "t_read_idle");
    chk("t_read_rdata", c1_rdata, 8'h3C);
    chk("t_read_done_lat", last_done_cyc[1] - last_ack_cyc, 1);
    chk("t_read_oe_never", oe_cnt, 0);
    eng_rfix = -1;

    // Both clients request together out of reset and keep requesting
    do_reset(); tick();
    gnt_log.delete();
    eng_delay = -1; keep0 = 1; keep1 = 1;
    c0_req = 1'b1; rand0(); c1_req = 1'b1; rand1();
    for (int i = 0; i < 500 && gnt_log.size() < 4; i++) tick();
    chk("t_fair_count", (gnt_log.size() >= 4) ? 1 : 0, 1);
    if (gnt_log.size() >= 4) begin
      chk("t_fair_0", gnt_log[0], 0);
      chk("t_fair_1", gnt_log[1], 1);
      chk("t_fair_2", gnt_log[2], 0);
      chk("t_fair_3", gnt_log[3], 1);
    end
    keep0 = 0; keep1 = 0;
    wait_idle(500, "t_fair_idle");

    // Write followed by a queued read: the read waits out tWR
    eng_delay = 5;
    c0_req = 1'b1; c0_we = 1'b1; c0_addr = 11'h055; c0_wdata = 8'h5A;
    for (int i = 0; i < 20 && !c0_gnt; i++) tick();
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 11'h066;
    wait_idle(200, "t_queue_idle");
    chk("t_queue_gap", last_gnt_cyc[1] - last_done_cyc[0], 9);

    // Reset while waiting for the engine ack
    eng_hang = 1; done_cnt0 = 0;
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = 11'h321;
    for (int i = 0; i < 20 && !eng_rd; i++) tick();
    repeat (5) tick();
    do_reset();
    chk("t_rst_busy", busy, 0);
    chk("t_rst_done", c0_done, 0);
    chk("t_rst_addr", eng_addr, 11'h000);
    eng_hang = 0;
    repeat (5) tick();
    chk("t_rst_no_done", done_cnt0, 0);
    eng_delay = 2;
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 11'h100; c1_wdata = 8'h11;
    last_gnt_cyc[1] = -1;
    for (int i = 0; i < 10 && last_gnt_cyc[1] < 0; i++) tick();
    chk("t_rst_regrant", (last_gnt_cyc[1] >= 0) ? 1 : 0, 1);
    wait_idle(100, "t_rst_idle");

    // Engine never acks
    eng_hang = 1; done_cnt0 = 0;
    c0_req = 1'b1; c0_we = 1'b1; c0_addr = 11'h0AA; c0_wdata = 8'h77;
`ifdef EEPROM_ARB_TIMEOUT_EN
    wait_idle(400, "t_to_idle");
    chk("t_to_lat", last_done_cyc[0] - last_strobe_cyc, TO);
    chk("t_to_err", last_err0, 1);
    chk("t_to_wrcyc", fall_cyc - last_done_cyc[0], 8);
    eng_pend = 0; eng_hang = 0;
`else
    repeat (300) tick();
    chk("t_hang_busy", busy, 1);
    chk("t_hang_no_done", done_cnt0, 0);
    eng_hang = 0;
    do_reset();
`endif
    tick();

    // Randomized traffic with spurious acks and occasional resets
    eng_delay = -1; spur = 1; rand_rst = 1; p0 = 25; p1 = 25;
    for (int k = 0; k < 15; k++) begin
      keep0 = 1'($urandom_range(1)); keep1 = 1'($urandom_range(1));
      repeat (200) tick();
    end
    rand_rst = 0; rst_req = 0; spur = 0; p0 = 0; p1 = 0; keep0 = 0; keep1 = 0;
    tick();
    wait_idle(500, "t_rand_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
